// File: rtl/sram_memory_controller_pkg.sv
// Shared memory-bus types for the SRAM memory controller: access sizes, operation codes,
// controller states and the size-to-byte-count helper.
package memory_bus_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_size_e;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS0,
      ST_WAIT0,
      ST_ACCESS1,
      ST_WAIT1,
      ST_RESPOND
   } ctrl_state_e;

   // Encoding 3 is not a legal size and is treated as a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/sram_memory_controller_if.sv
// CPU-side request/response bus of the SRAM memory controller.
// The CPU side uses the master modport; the controller uses the slave modport.
interface sram_memory_controller_if;
   logic        memory_enable;
   logic        memory_operation;
   logic [1:0]  memory_data_size;
   logic [31:0] memory_address;
   logic [31:0] memory_data_out;
   logic [31:0] memory_data_in;
   logic        memory_ready;
   logic        memory_fault;

   modport master (
      output memory_enable, memory_operation, memory_data_size, memory_address, memory_data_out,
      input  memory_data_in, memory_ready, memory_fault
   );

   modport slave (
      input  memory_enable, memory_operation, memory_data_size, memory_address, memory_data_out,
      output memory_data_in, memory_ready, memory_fault
   );
endinterface

// File: rtl/sram_memory_controller_lane_shifter.sv
// Byte-lane alignment for the SRAM controller: lane mask spanning two words,
// write data shifted onto lanes, and LSB-justified read extraction.
module memory_lane_shifter
   import memory_bus_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_write_data,
   input  logic [31:0] i_read_word0,
   input  logic [31:0] i_read_word1,
   output logic [7:0]  o_mask8,
   output logic [63:0] o_write_data64,
   output logic [31:0] o_read_data
);

   logic [2:0]  w_bytes;
   logic [3:0]  w_lanes;
   logic [5:0]  w_shift;
   logic [31:0] w_keep;

   always_comb begin
      w_bytes        = size_bytes(i_size);
      w_lanes        = 4'((5'd1 << w_bytes) - 5'd1);
      w_shift        = {1'b0, i_offset, 3'b000};
      w_keep         = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
      o_mask8        = {4'b0000, w_lanes} << i_offset;
      o_write_data64 = {32'h0000_0000, i_write_data} << w_shift;
      // Bytes beyond the request size are forced to zero (zero extension).
      o_read_data    = 32'({i_read_word1, i_read_word0} >> w_shift) & w_keep;
   end

endmodule

// File: rtl/sram_memory_controller.sv
// CPU memory port to 32-bit word SRAM controller with byte-lane alignment and bounds checking.
// Build option: define MISALIGNED_SPLIT_EN to split word-crossing accesses into two SRAM accesses.
module sram_memory_controller
   import memory_bus_pkg::*;
#(
   parameter  int unsigned RAM_BYTES       = 65536,
   localparam int unsigned WORD_ADDR_WIDTH = $clog2(RAM_BYTES / 4)
) (
   input  logic                       clock,
   input  logic                       reset,
   sram_memory_controller_if.slave    bus,
   output logic                       sram_enable,
   output logic                       sram_write_enable,
   output logic [3:0]                 sram_byte_enable,
   output logic [WORD_ADDR_WIDTH-1:0] sram_address,
   output logic [31:0]                sram_write_data,
   input  logic [31:0]                sram_read_data
);

   ctrl_state_e                r_state;
   logic [WORD_ADDR_WIDTH-1:0] r_word0;
   logic [1:0]                 r_off;
   logic [1:0]                 r_size;
   logic                       r_op;
   logic                       r_split;
   logic [31:0]                r_wdata;
   logic [31:0]                r_rdata0;
   logic [31:0]                r_data_in;
   logic                       r_ready;
   logic                       r_fault;

   logic                       w_idle;
   logic [1:0]                 w_size;
   logic [1:0]                 w_off;
   logic [7:0]                 w_mask8;
   logic [63:0]                w_wdata64;
   logic [31:0]                w_rd_word0;
   logic [31:0]                w_read_data;
   logic [32:0]                w_in_end;
   logic                       w_oob;
   logic                       w_split;
   logic                       w_fault;
   logic                       w_access;
   logic                       w_second;

   assign bus.memory_data_in = r_data_in;
   assign bus.memory_ready   = r_ready;
   assign bus.memory_fault   = r_fault;

   // In IDLE the shifter looks at the incoming request so the split/fault decision is made at capture.
   always_comb begin
      w_idle     = (r_state == ST_IDLE);
      w_size     = w_idle ? bus.memory_data_size : r_size;
      w_off      = w_idle ? bus.memory_address[1:0] : r_off;
      w_rd_word0 = (r_state == ST_WAIT1) ? r_rdata0 : sram_read_data;
      w_in_end   = {1'b0, bus.memory_address} + 33'(size_bytes(bus.memory_data_size));
      w_oob      = (w_in_end > 33'(RAM_BYTES));
      w_split    = |w_mask8[7:4];
`ifdef MISALIGNED_SPLIT_EN
      w_fault    = w_oob;
`else
      w_fault    = w_oob || w_split;
`endif
   end

   memory_lane_shifter u_lane_shifter (
      .i_size         (w_size),
      .i_offset       (w_off),
      .i_write_data   (r_wdata),
      .i_read_word0   (w_rd_word0),
      .i_read_word1   (sram_read_data),
      .o_mask8        (w_mask8),
      .o_write_data64 (w_wdata64),
      .o_read_data    (w_read_data)
   );

   // SRAM strobes decode straight from the state; no access may leave in a reset cycle.
   always_comb begin
      w_access          = (r_state == ST_ACCESS0) || (r_state == ST_ACCESS1);
      w_second          = (r_state == ST_ACCESS1);
      sram_enable       = !reset && w_access;
      sram_write_enable = w_access && (r_op == MEM_WRITE);
      sram_byte_enable  = 4'b0000;
      if (sram_write_enable) begin
         sram_byte_enable = w_second ? w_mask8[7:4] : w_mask8[3:0];
      end
      sram_address      = w_second ? (r_word0 + WORD_ADDR_WIDTH'(1)) : r_word0;
      sram_write_data   = w_second ? w_wdata64[63:32] : w_wdata64[31:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_word0   <= '0;
         r_off     <= 2'b00;
         r_size    <= 2'b00;
         r_op      <= MEM_READ;
         r_split   <= 1'b0;
         r_wdata   <= 32'h0;
         r_rdata0  <= 32'h0;
         r_data_in <= 32'h0;
         r_ready   <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.memory_enable && !r_ready) begin
                  r_word0 <= bus.memory_address[WORD_ADDR_WIDTH+1:2];
                  r_off   <= bus.memory_address[1:0];
                  r_size  <= bus.memory_data_size;
                  r_op    <= bus.memory_operation;
                  r_wdata <= bus.memory_data_out;
                  r_split <= w_split;
                  if (w_fault) begin
                     r_state   <= ST_RESPOND;
                     r_ready   <= 1'b1;
                     r_fault   <= 1'b1;
                     r_data_in <= 32'h0;
                  end else begin
                     r_state <= ST_ACCESS0;
                  end
               end
            end
            ST_ACCESS0: begin
               if (r_op == MEM_WRITE) begin
                  if (r_split) begin
                     r_state <= ST_ACCESS1;
                  end else begin
                     r_state <= ST_RESPOND;
                     r_ready <= 1'b1;
                  end
               end else begin
                  r_state <= ST_WAIT0;
               end
            end
            ST_WAIT0: begin
               r_rdata0 <= sram_read_data;
               if (r_split) begin
                  r_state <= ST_ACCESS1;
               end else begin
                  r_state   <= ST_RESPOND;
                  r_ready   <= 1'b1;
                  r_data_in <= w_read_data;
               end
            end
            ST_ACCESS1: begin
               if (r_op == MEM_WRITE) begin
                  r_state <= ST_RESPOND;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= ST_WAIT1;
               end
            end
            ST_WAIT1: begin
               r_state   <= ST_RESPOND;
               r_ready   <= 1'b1;
               r_data_in <= w_read_data;
            end
            ST_RESPOND: begin
               if (!bus.memory_enable) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b0;
                  r_fault <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
               r_fault <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_memory_controller.sv
// Self-checking bench for sram_memory_controller: vector table driven through a scoreboard,
// a byte-array reference model, and hand sequences for hold, input change and reset abort.
module tb_sram_memory_controller;
   import memory_bus_pkg::*;

   localparam int unsigned RAM_BYTES = 65536;
   localparam int unsigned WAW       = $clog2(RAM_BYTES / 4);
   localparam int unsigned WORDS     = RAM_BYTES / 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   sram_memory_controller_if bus ();

   logic           sram_enable;
   logic           sram_write_enable;
   logic [3:0]     sram_byte_enable;
   logic [WAW-1:0] sram_address;
   logic [31:0]    sram_write_data;
   logic [31:0]    sram_read_data;

   sram_memory_controller #(.RAM_BYTES(RAM_BYTES)) dut (
      .clock             (clock),
      .reset             (reset),
      .bus               (bus),
      .sram_enable       (sram_enable),
      .sram_write_enable (sram_write_enable),
      .sram_byte_enable  (sram_byte_enable),
      .sram_address      (sram_address),
      .sram_write_data   (sram_write_data),
      .sram_read_data    (sram_read_data)
   );

   always #5 clock = ~clock;

   // SRAM model plus access monitor
   logic [31:0]    sram_mem [WORDS];
   logic [7:0]     model_mem [RAM_BYTES];
   int             acc_cnt;
   logic [WAW-1:0] last_addr;
   logic [3:0]     last_be;

   always @(posedge clock) begin
      if (sram_enable) begin
         acc_cnt   <= acc_cnt + 1;
         last_addr <= sram_address;
         last_be   <= sram_byte_enable;
         if (sram_write_enable) begin
            for (int i = 0; i < 4; i++)
               if (sram_byte_enable[i]) sram_mem[sram_address][8*i +: 8] <= sram_write_data[8*i +: 8];
         end else begin
            sram_read_data <= sram_mem[sram_address];
         end
      end
   end

   typedef struct {
      logic        op;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_fault;
      int          exp_lat;
      int          exp_acc;
      int          exp_last_addr;
      logic [3:0]  exp_be;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        fault;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_data = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] size);
      logic [31:0] r = 32'h0;
      for (int i = 0; i < nbytes(size); i++) r[8*i +: 8] = model_mem[16'(addr + 32'(i))];
      return r;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
      for (int i = 0; i < nbytes(size); i++) model_mem[16'(addr + 32'(i))] = d[8*i +: 8];
   endtask

   function automatic logic [31:0] model_word(input int w);
      return {model_mem[16'(4*w+3)], model_mem[16'(4*w+2)], model_mem[16'(4*w+1)], model_mem[16'(4*w)]};
   endfunction

   task automatic init_word(input int w, input logic [31:0] val);
      sram_mem[w] = val;
      for (int i = 0; i < 4; i++) model_mem[16'(4*w+i)] = val[8*i +: 8];
   endtask

   task automatic run_req(input vec_t v, input string name, input int hold, input bit scramble);
      exp_t e;
      int   lat;
      bit   done;
      int   w0;
      @(negedge clock);
      acc_cnt = 0;
      bus.memory_enable    = 1'b1;
      bus.memory_operation = v.op;
      bus.memory_data_size = v.size;
      bus.memory_address   = v.addr;
      bus.memory_data_out  = v.wdata;
      if (v.exp_fault) begin
         e.data = 32'h0; e.fault = 1'b1; last_data = 32'h0;
      end else if (v.op == MEM_READ) begin
         e.data = model_read(v.addr, v.size); e.fault = 1'b0; last_data = e.data;
      end else begin
         e.data = last_data; e.fault = 1'b0; model_write(v.addr, v.size, v.wdata);
      end
      sb.push_back(e);
      lat = 0; done = 1'b0;
      while (!done && lat < 20) begin
         @(negedge clock);
         lat++;
         if (scramble && lat == 1) begin
            bus.memory_address   = $urandom();
            bus.memory_data_out  = $urandom();
            bus.memory_data_size = 2'($urandom_range(0, 3));
            bus.memory_operation = 1'($urandom_range(0, 1));
         end
         if (bus.memory_ready) done = 1'b1;
      end
      check({name, " ready_seen"}, 32'(done), 32'd1);
      e = sb.pop_front();
      if (done) begin
         check({name, " data"}, bus.memory_data_in, e.data);
         check({name, " fault"}, 32'(bus.memory_fault), 32'(e.fault));
         check({name, " latency"}, lat, v.exp_lat);
         check({name, " sram_accesses"}, acc_cnt, v.exp_acc);
         if (v.exp_acc > 0) check({name, " sram_last_addr"}, 32'(last_addr), v.exp_last_addr);
         if (v.op == MEM_WRITE && !v.exp_fault) begin
            check({name, " sram_last_be"}, 32'(last_be), 32'(v.exp_be));
            w0 = int'(v.addr[15:2]);
            check({name, " sram_word0"}, sram_mem[w0], model_word(w0));
            if (w0 + 1 < int'(WORDS)) check({name, " sram_word1"}, sram_mem[w0+1], model_word(w0+1));
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         check({name, " ready_held"}, 32'(bus.memory_ready), 32'd1);
         check({name, " fault_held"}, 32'(bus.memory_fault), 32'(e.fault));
      end
      bus.memory_enable = 1'b0;
      @(negedge clock);
      check({name, " ready_fall"}, 32'(bus.memory_ready), 32'd0);
      check({name, " fault_fall"}, 32'(bus.memory_fault), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      for (int w = 0; w < int'(WORDS); w++) init_word(w, 32'h0);
      init_word(0, 32'h4433_2211);
      init_word(1, 32'h8877_6655);
      init_word(4, 32'hDEAD_BEEF);
      init_word(8, 32'h4433_2211);
      init_word(int'(WORDS) - 1, 32'hCAFE_F00D);
      acc_cnt              = 0;
      sram_read_data       = 32'h0;
      bus.memory_enable    = 1'b0;
      bus.memory_operation = MEM_READ;
      bus.memory_data_size = 2'd0;
      bus.memory_address   = 32'h0;
      bus.memory_data_out  = 32'h0;

      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset ready", 32'(bus.memory_ready), 32'd0);
      check("reset fault", 32'(bus.memory_fault), 32'd0);
      check("reset data_in", bus.memory_data_in, 32'h0);
      check("reset sram_enable", 32'(sram_enable), 32'd0);
      reset = 1'b0;

      vecs.push_back('{MEM_READ,  SIZE_WORD, 32'h10, 32'h0, 1'b0, 3, 1, 4, 4'h0});
      vecs.push_back('{MEM_WRITE, SIZE_BYTE, 32'h13, 32'hA5, 1'b0, 2, 1, 4, 4'b1000});
      vecs.push_back('{MEM_READ,  SIZE_HALF, 32'h21, 32'h0, 1'b0, 3, 1, 8, 4'h0});
      vecs.push_back('{MEM_READ,  SIZE_BYTE, 32'h13, 32'h0, 1'b0, 3, 1, 4, 4'h0});
`ifdef MISALIGNED_SPLIT_EN
      vecs.push_back('{MEM_READ,  SIZE_WORD, 32'h02, 32'h0, 1'b0, 5, 2, 1, 4'h0});
      vecs.push_back('{MEM_WRITE, SIZE_WORD, 32'h06, 32'h1122_3344, 1'b0, 3, 2, 2, 4'b0011});
`else
      vecs.push_back('{MEM_READ,  SIZE_WORD, 32'h02, 32'h0, 1'b1, 1, 0, 0, 4'h0});
      vecs.push_back('{MEM_WRITE, SIZE_WORD, 32'h06, 32'h1122_3344, 1'b1, 1, 0, 0, 4'h0});
`endif
      vecs.push_back('{MEM_WRITE, SIZE_HALF, 32'h41, 32'hBEEF, 1'b0, 2, 1, 16, 4'b0110});
      vecs.push_back('{MEM_READ,  SIZE_HALF, 32'h41, 32'h0, 1'b0, 3, 1, 16, 4'h0});
      vecs.push_back('{MEM_WRITE, SIZE_WORD, RAM_BYTES - 2, 32'h5555_AAAA, 1'b1, 1, 0, 0, 4'h0});
      vecs.push_back('{MEM_READ,  SIZE_WORD, RAM_BYTES - 4, 32'h0, 1'b0, 3, 1, int'(WORDS) - 1, 4'h0});
      vecs.push_back('{MEM_READ,  2'd3,      32'h10, 32'h0, 1'b0, 3, 1, 4, 4'h0});
      vecs.push_back('{MEM_READ,  SIZE_BYTE, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 0, 4'h0});
      vecs.push_back('{MEM_WRITE, SIZE_WORD, 32'h20, 32'h1234_5678, 1'b0, 2, 1, 8, 4'b1111});
      vecs.push_back('{MEM_READ,  SIZE_BYTE, 32'h23, 32'h0, 1'b0, 3, 1, 8, 4'h0});

      for (int i = 0; i < vecs.size(); i++) run_req(vecs[i], $sformatf("vec%0d", i), 0, 1'b0);

      // Response held while the CPU keeps its request asserted
      run_req('{MEM_READ, SIZE_BYTE, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 0, 4'h0}, "fault_hold", 3, 1'b0);
      run_req('{MEM_READ, SIZE_WORD, 32'h10, 32'h0, 1'b0, 3, 1, 4, 4'h0}, "read_hold", 2, 1'b0);

      // Inputs changed after capture must not affect the access
      run_req('{MEM_READ, SIZE_WORD, 32'h10, 32'h0, 1'b0, 3, 1, 4, 4'h0}, "input_change", 0, 1'b1);

      // Reset during ACCESS0 suppresses the SRAM strobe
      @(negedge clock);
      bus.memory_enable    = 1'b1;
      bus.memory_operation = MEM_READ;
      bus.memory_data_size = SIZE_WORD;
      bus.memory_address   = 32'h10;
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("reset_access0 sram_enable", 32'(sram_enable), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      bus.memory_enable = 1'b0;
      @(negedge clock);

      // Reset during WAIT0 aborts the read
      bus.memory_enable = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("reset_wait0 ready", 32'(bus.memory_ready), 32'd0);
      check("reset_wait0 data_in", bus.memory_data_in, 32'h0);
      reset = 1'b0;
      bus.memory_enable = 1'b0;
      last_data = 32'h0;
      @(negedge clock);
      check("post_reset idle ready", 32'(bus.memory_ready), 32'd0);
      run_req('{MEM_READ, SIZE_BYTE, 32'h10, 32'h0, 1'b0, 3, 1, 4, 4'h0}, "after_reset", 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
